// File: rtl/ant_colony_sched_pkg.sv
// Shared move codes, widths and scheduler state type for the ant colony scheduler.
package ant_colony_sched_pkg;
  localparam logic [1:0] MV_HALT    = 2'b00;
  localparam logic [1:0] MV_RIGHT   = 2'b01;
  localparam logic [1:0] MV_LEFT    = 2'b10;
  localparam logic [1:0] MV_FORWARD = 2'b11;

  localparam int PH_WIDTH_DEF = 2;
  localparam int CYC_W        = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PICK,
    ST_RUN,
    ST_DONE
  } state_t;
endpackage

// File: rtl/ant_colony_sched_if.sv
// Maze-engine handshake bundle: scheduler is master, maze model is slave.
interface ant_colony_sched_if #(
  parameter int PH_WIDTH = 2
);
  logic                maze_valid;
  logic                maze_ready;
  logic [1:0]          maze_move;
  logic [PH_WIDTH-1:0] maze_ph_drop;
  logic                maze_escape;

  modport master (
    output maze_valid, maze_move, maze_ph_drop,
    input  maze_ready, maze_escape
  );

  modport slave (
    input  maze_valid, maze_move, maze_ph_drop,
    output maze_ready, maze_escape
  );
endinterface

// File: rtl/ant_colony_sched_rr_pick.sv
// Round-robin picker: first eligible index at or after ptr, wrapping to 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          found
);
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    // k is the distance from ptr; the first eligible hit in distance order wins
    for (int unsigned k = 0; k < N; k++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && eligible[i] && (i == (32'(ptr) + k) % N)) begin
          grant[i]  = 1'b1;
          grant_idx = IW'(i);
          found     = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/ant_colony_sched.sv
// Round-robin scheduler sharing one maze engine among N_ANT ant controllers,
// with per-ant pheromone budgets, sticky escape flags and a global cycle limit.
module ant_colony_sched
  import ant_colony_sched_pkg::*;
#(
  parameter int N_ANT    = 4,
  parameter int PH_WIDTH = PH_WIDTH_DEF,
  parameter int TURN_LEN = 8,
  parameter int BUDGET   = 6,
  parameter int MAX_CYC  = 1023
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [2*N_ANT-1:0]        ant_move,
  input  logic [PH_WIDTH*N_ANT-1:0] ant_ph_drop,
  output logic [N_ANT-1:0]          ant_sel,
  ant_colony_sched_if.master        maze,
  output logic [N_ANT-1:0]          escaped,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout
);
  localparam int IW = (N_ANT > 1) ? $clog2(N_ANT) : 1;
  localparam int BW = $clog2(BUDGET + 1);
  localparam int MW = $clog2(TURN_LEN + 1);

  state_t              state, state_nxt;
  logic [IW-1:0]       ptr, cur, cur_inc, pick_idx;
  logic [N_ANT-1:0]    cur_sel, pick_grant;
  logic                pick_found;
  logic [MW-1:0]       move_cnt;
  logic [CYC_W-1:0]    cyc_cnt;
  logic [BW-1:0]       budget [N_ANT];
  logic                timeout_r;
  logic [1:0]          moves [N_ANT];
  logic [PH_WIDTH-1:0] drops [N_ANT];
  logic [PH_WIDTH-1:0] fwd_ph;
  logic                at_limit, hs, turn_end;

  rr_pick #(
    .N  (N_ANT),
    .IW (IW)
  ) u_rr_pick (
    .eligible  (~escaped),
    .ptr       (ptr),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .found     (pick_found)
  );

  always_comb begin
    for (int unsigned i = 0; i < N_ANT; i++) begin
      moves[i] = ant_move[2*i +: 2];
      drops[i] = ant_ph_drop[i*PH_WIDTH +: PH_WIDTH];
    end
  end

  assign cur_inc = (cur == IW'(N_ANT - 1)) ? '0 : cur + IW'(1);
  assign timeout = timeout_r;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    ant_sel            = '0;
    maze.maze_valid    = 1'b0;
    maze.maze_move     = MV_HALT;
    maze.maze_ph_drop  = '0;
    fwd_ph             = '0;
    hs                 = 1'b0;
    turn_end           = 1'b0;
    busy               = (state == ST_PICK) || (state == ST_RUN);
    done               = (state == ST_DONE);
    at_limit           = busy && (cyc_cnt == CYC_W'(MAX_CYC));
    case (state)
      ST_IDLE: if (start) state_nxt = ST_PICK;
      ST_PICK: state_nxt = (at_limit || !pick_found) ? ST_DONE : ST_RUN;
      ST_RUN: begin
        // pass-through from the granted ant: a stalled move follows its source
        fwd_ph            = (budget[cur] != '0) ? drops[cur] : '0;
        ant_sel           = cur_sel;
        maze.maze_valid   = 1'b1;
        maze.maze_move    = moves[cur];
        maze.maze_ph_drop = fwd_ph;
        hs                = maze.maze_ready;
        turn_end          = hs && (move_cnt == MW'(TURN_LEN - 1));
        if (at_limit)                          state_nxt = ST_DONE;
        else if (maze.maze_escape || turn_end) state_nxt = ST_PICK;
      end
      ST_DONE: if (start) state_nxt = ST_PICK;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= '0;
      cur       <= '0;
      cur_sel   <= '0;
      move_cnt  <= '0;
      cyc_cnt   <= '0;
      escaped   <= '0;
      timeout_r <= 1'b0;
      for (int unsigned i = 0; i < N_ANT; i++) budget[i] <= BW'(BUDGET);
    end else begin
      if (busy) cyc_cnt <= cyc_cnt + CYC_W'(1);
      case (state)
        ST_PICK: begin
          if (at_limit) begin
            timeout_r <= 1'b1;
          end else if (pick_found) begin
            cur      <= pick_idx;
            cur_sel  <= pick_grant;
            move_cnt <= '0;
          end
        end
        ST_RUN: begin
          // hitting the cycle limit discards every other update of this cycle
          if (at_limit) begin
            timeout_r <= 1'b1;
          end else begin
            if (hs) begin
              move_cnt <= move_cnt + MW'(1);
              if (fwd_ph != '0) budget[cur] <= budget[cur] - BW'(1);
            end
            if (maze.maze_escape) begin
              escaped[cur] <= 1'b1;
              ptr          <= cur_inc;
            end else if (turn_end) begin
              ptr <= cur_inc;
            end
          end
        end
        ST_DONE: begin
          if (start) begin
            escaped   <= '0;
            cyc_cnt   <= '0;
            ptr       <= '0;
            timeout_r <= 1'b0;
            for (int unsigned i = 0; i < N_ANT; i++) budget[i] <= BW'(BUDGET);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ant_colony_sched.sv
// Self-checking bench for ant_colony_sched: turn table plus handshake scoreboard.
module tb_ant_colony_sched;
  import ant_colony_sched_pkg::*;

  localparam int N   = 4;
  localparam int PHW = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [2*N-1:0]   ant_move = '0;
  logic [PHW*N-1:0] ant_ph_drop = '0;
  logic [N-1:0]     ant_sel, escaped;
  logic             busy, done, timeout;

  ant_colony_sched_if #(.PH_WIDTH(PHW)) mif ();

  ant_colony_sched #(
    .N_ANT    (N),
    .PH_WIDTH (PHW),
    .TURN_LEN (8),
    .BUDGET   (6),
    .MAX_CYC  (1023)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ant_move    (ant_move),
    .ant_ph_drop (ant_ph_drop),
    .ant_sel     (ant_sel),
    .maze        (mif),
    .escaped     (escaped),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   sel;
    logic [1:0]     move;
    logic [PHW-1:0] ph;
  } exp_t;

  typedef struct {
    logic [N-1:0] sel;
    int           n;
    bit           esc;
  } turn_t;

  exp_t           sb[$];
  turn_t          tt[14];
  int             checks = 0;
  int             failures = 0;
  int             bud[N];
  logic [PHW-1:0] drop_cfg[N];
  logic [N-1:0]   exp_esc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // one handshaken move by the granted ant; entered and left at posedge+1
  task automatic step_move(input int ant, input bit esc);
    exp_t e, got;
    for (int i = 0; i < N; i++) begin
      ant_move[2*i +: 2]      = 2'($urandom_range(0, 3));
      ant_ph_drop[PHW*i +: PHW] = drop_cfg[i];
    end
    mif.maze_ready  = 1'b1;
    mif.maze_escape = esc;
    e.sel  = 4'(1 << ant);
    e.move = ant_move[2*ant +: 2];
    if (drop_cfg[ant] != '0 && bud[ant] > 0) begin
      e.ph = drop_cfg[ant];
      bud[ant]--;
    end else begin
      e.ph = '0;
    end
    sb.push_back(e);
    @(negedge clk);
    if (mif.maze_valid && mif.maze_ready && sb.size() > 0) begin
      got.sel  = ant_sel;
      got.move = mif.maze_move;
      got.ph   = mif.maze_ph_drop;
      e = sb.pop_front();
      chk("sb_sel", 32'(got.sel), 32'(e.sel));
      chk("sb_move", 32'(got.move), 32'(e.move));
      chk("sb_ph", 32'(got.ph), 32'(e.ph));
    end else begin
      chk("handshake_valid", 32'(mif.maze_valid), 32'd1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic gap_check();
    chk("gap_valid", 32'(mif.maze_valid), 32'd0);
    chk("gap_sel", 32'(ant_sel), 32'd0);
    chk("gap_busy", 32'(busy), 32'd1);
    chk("gap_escaped", 32'(escaped), 32'(exp_esc));
  endtask

  initial begin
    int ant;
    int cnt;

    tt = '{
      '{4'b0001, 8, 1'b0}, '{4'b0010, 8, 1'b0}, '{4'b0100, 8, 1'b0}, '{4'b1000, 8, 1'b0},
      '{4'b0001, 8, 1'b0}, '{4'b0010, 8, 1'b0}, '{4'b0100, 3, 1'b1}, '{4'b1000, 8, 1'b0},
      '{4'b0001, 8, 1'b0}, '{4'b0010, 8, 1'b0}, '{4'b1000, 8, 1'b0},
      '{4'b0001, 1, 1'b1}, '{4'b0010, 2, 1'b1}, '{4'b1000, 1, 1'b1}
    };
    mif.maze_ready  = 1'b0;
    mif.maze_escape = 1'b0;

    // reset and idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_sel", 32'(ant_sel), 32'd0);
    chk("rst_valid", 32'(mif.maze_valid), 32'd0);
    chk("rst_move", 32'(mif.maze_move), 32'(MV_HALT));
    chk("rst_ph", 32'(mif.maze_ph_drop), 32'd0);
    chk("rst_escaped", 32'(escaped), 32'd0);
    chk("rst_flags", {29'd0, busy, done, timeout}, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("idle_sel", 32'(ant_sel), 32'd0);
    chk("idle_valid", 32'(mif.maze_valid), 32'd0);
    chk("idle_flags", {29'd0, busy, done, timeout}, 32'd0);

    // round-robin run with budgets and escapes
    drop_cfg = '{2'd0, 2'd1, 2'd0, 2'd2};
    for (int i = 0; i < N; i++) bud[i] = 6;
    exp_esc = '0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("pick_valid", 32'(mif.maze_valid), 32'd0);
    chk("pick_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    for (int t = 0; t < 14; t++) begin
      ant = 0;
      for (int i = 0; i < N; i++) if (tt[t].sel[i]) ant = i;
      chk("grant_sel", 32'(ant_sel), 32'(tt[t].sel));
      chk("grant_valid", 32'(mif.maze_valid), 32'd1);
      for (int k = 0; k < tt[t].n; k++) step_move(ant, tt[t].esc && (k == tt[t].n - 1));
      mif.maze_ready  = 1'b0;
      mif.maze_escape = 1'b0;
      if (tt[t].esc) exp_esc = exp_esc | tt[t].sel;
      gap_check();
      @(posedge clk);
      #1;
    end
    chk("all_esc_done", 32'(done), 32'd1);
    chk("all_esc_timeout", 32'(timeout), 32'd0);
    chk("all_esc_busy", 32'(busy), 32'd0);
    chk("all_esc_sel", 32'(ant_sel), 32'd0);
    chk("all_esc_escaped", 32'(escaped), 32'hF);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    // stalled maze runs into the cycle limit
    drop_cfg = '{2'd0, 2'd0, 2'd0, 2'd0};
    ant_move = '0;
    ant_ph_drop = '0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cnt = 0;
    while (!done && cnt < 1100) begin
      @(posedge clk);
      #1 cnt++;
      if (cnt == 2) begin
        chk("restart_escaped", 32'(escaped), 32'd0);
        chk("restart_sel", 32'(ant_sel), 32'h1);
      end
      if (cnt == 5) begin
        ant_move[1:0] = MV_FORWARD;
        ant_ph_drop[1:0] = 2'd3;
        #1;
        chk("hold_move_a", 32'(mif.maze_move), 32'(MV_FORWARD));
        chk("hold_ph_a", 32'(mif.maze_ph_drop), 32'd3);
        ant_move[1:0] = MV_LEFT;
        ant_ph_drop[1:0] = 2'd1;
        #1;
        chk("hold_move_b", 32'(mif.maze_move), 32'(MV_LEFT));
        chk("hold_ph_b", 32'(mif.maze_ph_drop), 32'd1);
        ant_move[1:0] = MV_RIGHT;
        ant_ph_drop[1:0] = 2'd0;
      end
    end
    chk("timeout_cycles", 32'(cnt), 32'd1024);
    chk("to_done", 32'(done), 32'd1);
    chk("to_timeout", 32'(timeout), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_valid", 32'(mif.maze_valid), 32'd0);

    // restart, escape ant0, then reset mid-run
    ant_move = '0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("rs_flags", {29'd0, busy, done, timeout}, 32'h4);
    @(posedge clk);
    #1;
    chk("rs_sel0", 32'(ant_sel), 32'h1);
    for (int i = 0; i < N; i++) bud[i] = 6;
    step_move(0, 1'b1);
    mif.maze_ready  = 1'b0;
    mif.maze_escape = 1'b0;
    chk("rs_escaped", 32'(escaped), 32'h1);
    @(posedge clk);
    #1;
    chk("rs_sel1", 32'(ant_sel), 32'h2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_sel", 32'(ant_sel), 32'd0);
    chk("midrst_valid", 32'(mif.maze_valid), 32'd0);
    chk("midrst_escaped", 32'(escaped), 32'd0);
    chk("midrst_flags", {29'd0, busy, done, timeout}, 32'd0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_idle", {28'd0, mif.maze_valid, busy, done, timeout}, 32'd0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_sel", 32'(ant_sel), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
